// File: rtl/masked_bv8_gamma_pkg.sv
`default_nettype none
// masked_bv8_gamma_pkg: GF(2^4) tower arithmetic, share/randomness sizing and latencies
// for the masked Gamma stage of the S-box inverter.
package masked_bv8_gamma_pkg;

  typedef logic [3:0] bv4_t;
  typedef logic [7:0] bv8_t;

  // GF(2^4) = GF(2^2)[y]/(y^2+y+z), GF(2^2) = GF(2)[z]/(z^2+z+1); nu is the GF(2^8) scaling constant.
  localparam bv4_t NU = 4'h8;

  localparam int GAMMA_LATENCY   = 1;
  localparam int X_ALIGN_LATENCY = 3;

  function automatic int num_quad(input int n);
    return n * (n - 1) / 2;
  endfunction

  function automatic int masked_bv8_gamma_randoms(input int n);
    return 8 * num_quad(n);
  endfunction

  // Linear index of the unordered share pair {a,b}, a != b.
  function automatic int pair_idx(input int a, input int b, input int n);
    int lo;
    int hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return lo * n - lo * (lo + 1) / 2 + hi - lo - 1;
  endfunction

  function automatic logic [1:0] bv2_mul(input logic [1:0] a, input logic [1:0] b);
    logic hh;
    hh = a[1] & b[1];
    return {hh ^ (a[1] & b[0]) ^ (a[0] & b[1]), hh ^ (a[0] & b[0])};
  endfunction

  function automatic logic [1:0] bv2_mul_z(input logic [1:0] a);
    return {a[1] ^ a[0], a[1]};
  endfunction

  function automatic bv4_t bv4_mul(input bv4_t a, input bv4_t b);
    logic [1:0] hh;
    hh = bv2_mul(a[3:2], b[3:2]);
    return {hh ^ bv2_mul(a[3:2], b[1:0]) ^ bv2_mul(a[1:0], b[3:2]),
            bv2_mul_z(hh) ^ bv2_mul(a[1:0], b[1:0])};
  endfunction

  function automatic bv4_t bv4_sq_scl(input bv4_t a);
    return bv4_mul(NU, bv4_mul(a, a));
  endfunction

endpackage
`default_nettype wire

// File: rtl/masked_bv8_gamma_if.sv
`default_nettype none
// masked_bv8_gamma_if: masked input/Gamma/xh-xl bundle between a producer and masked_bv8_gamma.
interface masked_bv8_gamma_if #(
  parameter int NUM_SHARES = 2
);
  import masked_bv8_gamma_pkg::*;

  localparam int NUM_RANDOM = masked_bv8_gamma_randoms(NUM_SHARES);

  bv8_t [NUM_SHARES-1:0]  in_x;
  logic                   in_valid;
  logic [NUM_RANDOM-1:0]  in_random;
  bv4_t [NUM_SHARES-1:0]  out_gamma;
  logic                   out_gamma_valid;
  bv4_t [NUM_SHARES-1:0]  out_xh;
  bv4_t [NUM_SHARES-1:0]  out_xl;
  logic                   out_x_valid;

  modport master (
    output in_x, in_valid, in_random,
    input  out_gamma, out_gamma_valid, out_xh, out_xl, out_x_valid
  );

  modport slave (
    input  in_x, in_valid, in_random,
    output out_gamma, out_gamma_valid, out_xh, out_xl, out_x_valid
  );

endinterface
`default_nettype wire

// File: rtl/masked_hpc3_bv4_mul.sv
`default_nettype none
// masked_hpc3_bv4_mul: one-cycle HPC3-style masked GF(2^4) multiplier, out_c = in_a * in_b (shared).
module masked_hpc3_bv4_mul
  import masked_bv8_gamma_pkg::*;
#(
  parameter int NUM_SHARES = 2
) (
  input  logic                              in_clock,
  input  logic                              in_reset,
  input  bv4_t [NUM_SHARES-1:0]             in_a,
  input  bv4_t [NUM_SHARES-1:0]             in_b,
  input  logic [4*num_quad(NUM_SHARES)-1:0] in_r,
  input  logic [4*num_quad(NUM_SHARES)-1:0] in_p,
  output bv4_t [NUM_SHARES-1:0]             out_c
);
  localparam int NUM_TERMS = 2 * NUM_SHARES - 1;

  for (genvar i = 0; i < NUM_SHARES; i++) begin : g_share
    bv4_t term_d [NUM_TERMS];
    bv4_t term_q [NUM_TERMS];
    bv4_t acc;
    bv4_t rnd;
    bv4_t msk;
    int   slot;

    // Slot 0 holds the inner product; each foreign share j owns a pair of slots whose r terms cancel.
    always_comb begin
      slot   = 0;
      rnd    = '0;
      msk    = '0;
      term_d = '{default: '0};
      term_d[0] = bv4_mul(in_a[i], in_b[i]);
      for (int j = 0; j < NUM_SHARES; j++) begin
        if (j != i) begin
          slot = (j < i) ? 2 * j + 1 : 2 * j - 1;
          rnd  = in_r[4*pair_idx(i, j, NUM_SHARES) +: 4];
          msk  = in_p[4*pair_idx(i, j, NUM_SHARES) +: 4];
          term_d[slot]     = bv4_mul(in_a[i], in_b[j] ^ rnd) ^ msk;
          term_d[slot + 1] = bv4_mul(in_a[i] ^ 4'h1, rnd) ^ msk;
        end
      end
    end

    always_ff @(posedge in_clock) begin
      if (in_reset) begin
        for (int k = 0; k < NUM_TERMS; k++) term_q[k] <= '0;
      end else begin
        for (int k = 0; k < NUM_TERMS; k++) term_q[k] <= term_d[k];
      end
    end

    always_comb begin
      acc = term_q[0];
      for (int k = 1; k < NUM_TERMS; k++) acc = acc ^ term_q[k];
    end

    assign out_c[i] = acc;
  end

endmodule
`default_nettype wire

// File: rtl/masked_bv8_gamma.sv
`default_nettype none
// masked_bv8_gamma: masked Gamma = xh*xl ^ nu*(xh^xl)^2 (1 cycle) plus delay-aligned xh/xl.
// MASKED_BV8_GAMMA_DELAY_EN builds the 3-stage xh/xl line; otherwise xh/xl leave at t1 with Gamma.
module masked_bv8_gamma
  import masked_bv8_gamma_pkg::*;
#(
  parameter int NUM_SHARES = 2
) (
  input  logic              in_clock,
  input  logic              in_reset,
  masked_bv8_gamma_if.slave bus
);
  localparam int NUM_QUAD = num_quad(NUM_SHARES);

`ifdef MASKED_BV8_GAMMA_DELAY_EN
  localparam int X_STAGES = X_ALIGN_LATENCY;
`else
  localparam int X_STAGES = GAMMA_LATENCY;
`endif

  bv4_t [NUM_SHARES-1:0] xh;
  bv4_t [NUM_SHARES-1:0] xl;
  bv4_t [NUM_SHARES-1:0] prod;
  bv4_t [NUM_SHARES-1:0] s_d;
  bv4_t [NUM_SHARES-1:0] s_q;
  bv4_t [NUM_SHARES-1:0] xh_q [X_STAGES];
  bv4_t [NUM_SHARES-1:0] xl_q [X_STAGES];
  logic [X_STAGES-1:0]   v_q;

  for (genvar i = 0; i < NUM_SHARES; i++) begin : g_split
    assign xh[i]            = bus.in_x[i][7:4];
    assign xl[i]            = bus.in_x[i][3:0];
    assign s_d[i]           = bv4_sq_scl(xh[i] ^ xl[i]);
    assign bus.out_gamma[i] = prod[i] ^ s_q[i];
  end

  masked_hpc3_bv4_mul #(
    .NUM_SHARES (NUM_SHARES)
  ) u_mul (
    .in_clock (in_clock),
    .in_reset (in_reset),
    .in_a     (xh),
    .in_b     (xl),
    .in_r     (bus.in_random[4*NUM_QUAD-1:0]),
    .in_p     (bus.in_random[8*NUM_QUAD-1:4*NUM_QUAD]),
    .out_c    (prod)
  );

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      s_q <= '0;
      v_q <= '0;
      for (int k = 0; k < X_STAGES; k++) begin
        xh_q[k] <= '0;
        xl_q[k] <= '0;
      end
    end else begin
      s_q     <= s_d;
      v_q[0]  <= bus.in_valid;
      xh_q[0] <= xh;
      xl_q[0] <= xl;
      for (int k = 1; k < X_STAGES; k++) begin
        v_q[k]  <= v_q[k-1];
        xh_q[k] <= xh_q[k-1];
        xl_q[k] <= xl_q[k-1];
      end
    end
  end

  assign bus.out_gamma_valid = v_q[0];
  assign bus.out_x_valid     = v_q[X_STAGES-1];
  assign bus.out_xh          = xh_q[X_STAGES-1];
  assign bus.out_xl          = xl_q[X_STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_masked_bv8_gamma.sv
`default_nettype none
// tb_masked_bv8_gamma: directed stimulus with a queue scoreboard for masked_bv8_gamma.
module tb_masked_bv8_gamma;
  import masked_bv8_gamma_pkg::*;

  localparam int NS    = 2;
  localparam int NR    = masked_bv8_gamma_randoms(NS);
  localparam int LIMIT = 3000;
`ifdef MASKED_BV8_GAMMA_DELAY_EN
  localparam int X_LAT = 3;
`else
  localparam int X_LAT = 1;
`endif

  typedef struct {
    logic [7:0] val;
    int         cyc;
    bit         mt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  bit   done = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t gq[$];
  exp_t xq[$];
  int   zq[$];
  logic [15:0] seen = '0;

  masked_bv8_gamma_if #(.NUM_SHARES(NS)) bus ();

  masked_bv8_gamma #(.NUM_SHARES(NS)) dut (
    .in_clock (clk),
    .in_reset (rst),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Independent reference: operand b expanded over basis {1, z, y, yz}.
  function automatic logic [1:0] g4_z(input logic [1:0] a);
    return {a[1] ^ a[0], a[1]};
  endfunction
  function automatic logic [3:0] g16_z(input logic [3:0] a);
    return {g4_z(a[3:2]), g4_z(a[1:0])};
  endfunction
  function automatic logic [3:0] g16_y(input logic [3:0] a);
    return {a[3:2] ^ a[1:0], g4_z(a[3:2])};
  endfunction
  function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    acc = 4'h0;
    if (b[0]) acc ^= a;
    if (b[1]) acc ^= g16_z(a);
    if (b[2]) acc ^= g16_y(a);
    if (b[3]) acc ^= g16_z(g16_y(a));
    return acc;
  endfunction
  function automatic logic [3:0] ref_gamma(input logic [7:0] x);
    logic [3:0] s;
    s = x[7:4] ^ x[3:0];
    return ref_mul(x[7:4], x[3:0]) ^ ref_mul(ref_mul(s, s), 4'h8);
  endfunction

  function automatic logic [3:0] unsh4(input logic [NS-1:0][3:0] v);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 0; i < NS; i++) r ^= v[i];
    return r;
  endfunction

  task automatic drive(input logic [7:0] x, input bit vld, input bit rs,
                       input logic [3:0] gexp, input bit mt);
    logic [7:0] acc;
    exp_t e;
    @(posedge clk);
    #1;
    acc = x;
    for (int i = 0; i < NS - 1; i++) begin
      bus.in_x[i] = 8'($urandom);
      acc ^= bus.in_x[i];
    end
    bus.in_x[NS-1] = acc;
    for (int k = 0; k < NR; k++) bus.in_random[k] = 1'($urandom);
    bus.in_valid = vld;
    rst = rs;
    if (rs) begin
      while (gq.size() > 0 && gq[$].cyc > cyc) void'(gq.pop_back());
      while (xq.size() > 0 && xq[$].cyc > cyc) void'(xq.pop_back());
      zq.push_back(cyc + 1);
    end else if (vld) begin
      e.val = {4'h0, gexp}; e.cyc = cyc + 1;     e.mt = mt;   gq.push_back(e);
      e.val = x;            e.cyc = cyc + X_LAT; e.mt = 1'b0; xq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(8'($urandom), 1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  // Hand-computed Gamma values for the chosen tower basis (nu = 0x8).
  logic [7:0] hv_x [6] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h02, 8'h53};
  logic [3:0] hv_g [6] = '{4'h0,  4'h8,  4'h8,  4'h1,  4'h4,  4'hC};

  initial begin : stimulus
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_x = '0;
    bus.in_random = '0;
    drive(8'h00, 1'b0, 1'b1, 4'h0, 1'b0);
    drive(8'h00, 1'b0, 1'b1, 4'h0, 1'b0);
    for (int k = 0; k < 6; k++) drive(hv_x[k], 1'b1, 1'b0, hv_g[k], 1'b0);
    idle(3);
    for (int v = 1; v < 16; v++) drive(8'(v), 1'b1, 1'b0, ref_gamma(8'(v)), 1'b0);
    for (int x = 0; x < 256; x++) drive(8'(x), 1'b1, 1'b0, ref_gamma(8'(x)), 1'b0);
    for (int k = 0; k < 100; k++) drive(8'h53, 1'b1, 1'b0, 4'hC, 1'b1);
    idle(4);
    for (int k = 0; k < 3; k++) drive(8'(8'hA0 + k), 1'b1, 1'b0, ref_gamma(8'(8'hA0 + k)), 1'b0);
    drive(8'h77, 1'b1, 1'b1, 4'h0, 1'b0);
    drive(8'h77, 1'b1, 1'b1, 4'h0, 1'b0);
    idle(6);
    drive(8'h53, 1'b1, 1'b0, 4'hC, 1'b0);
    idle(2);
    drive(8'h11, 1'b1, 1'b1, 4'h0, 1'b0);
    idle(12);
    done = 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h required %0h", nm, cyc, act, req);
  endtask

  initial begin : monitor
    exp_t e;
    bit   due;
    while (!done && cyc <= LIMIT) begin
      @(negedge clk);
      if (cyc >= 2) begin
        if (zq.size() > 0 && zq[0] == cyc) begin
          void'(zq.pop_front());
          chk("rst_gamma", 32'(bus.out_gamma), 32'h0);
          chk("rst_xh", 32'(bus.out_xh), 32'h0);
          chk("rst_xl", 32'(bus.out_xl), 32'h0);
        end
        due = (gq.size() > 0 && gq[0].cyc == cyc);
        chk("gamma_valid", 32'(bus.out_gamma_valid), 32'(due));
        if (due) begin
          e = gq.pop_front();
          chk("gamma_value", 32'(unsh4(bus.out_gamma)), 32'(e.val));
          if (e.mt) seen[bus.out_gamma[0]] = 1'b1;
        end
        due = (xq.size() > 0 && xq[0].cyc == cyc);
        chk("x_valid", 32'(bus.out_x_valid), 32'(due));
        if (due) begin
          e = xq.pop_front();
          chk("x_value", 32'({unsh4(bus.out_xh), unsh4(bus.out_xl)}), 32'(e.val));
        end
      end
    end
    if (!done) begin
      n_total++;
      $display("FAIL watchdog: got cyc %0d required completion by %0d", cyc, LIMIT);
    end
    chk("gamma_drained", 32'(gq.size()), 32'h0);
    chk("x_drained", 32'(xq.size()), 32'h0);
    chk("mask_share_varies", 32'($countones(seen) > 1), 32'h1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
